// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    localparam int         PC_INCR    = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_timeout_counter.sv
// Wait-cycle counter for the fetch request phase; only built with IFU_TIMEOUT_EN.
`ifdef IFU_TIMEOUT_EN
module ifu_timeout_counter
    import ifu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the wait cycle that brings the count to TIMEOUT.
    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one req/ack read per fetchStart, latching the word and PC+4.
// Optional request timeout is enabled by defining IFU_TIMEOUT_EN.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] pcIn,
    input  logic              fetchStart,
    input  logic              flush,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRdata,
    output logic [DATA_W-1:0] instrOut,
    output logic [ADDR_W-1:0] pcPlus4,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [1:0]        dbgState
);

    // memReq/memAck: memReq rises on entry to REQ and stays high with a stable
    // memAddr until the cycle memAck is sampled high (or flush/timeout); memAck
    // is only meaningful while memReq is high.

    ifu_state_e state_q, state_d;

    logic              mem_req_q,  mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
    logic [DATA_W-1:0] instr_q,    instr_d;
    logic              fault_q,    fault_d;

    logic start_ok;
    logic misaligned;
    logic to_expired;

    assign start_ok   = fetchStart && !flush;
    assign misaligned = |(pcIn[1:0] & ALIGN_MASK);

`ifdef IFU_TIMEOUT_EN
    ifu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (state_q != REQ),
        .enable_i  ((state_q == REQ) && !memAck && !flush),
        .expired_o (to_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign to_expired     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                // flush outranks a same-cycle memAck; the data is dropped.
                if (flush) begin
                    state_d = IDLE;
                end else if (memAck || to_expired) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    mem_addr_d = pcIn;
                    pc_plus4_d = pcIn + ADDR_W'(PC_INCR);
                    fault_d    = misaligned;
                    mem_req_d  = !misaligned;
                end
            end
            REQ: begin
                if (flush) begin
                    mem_req_d = 1'b0;
                end else if (memAck) begin
                    instr_d   = memRdata;
                    mem_req_d = 1'b0;
                end else if (to_expired) begin
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            pc_plus4_q <= '0;
            instr_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
        end
    end

    assign memReq   = mem_req_q;
    assign memAddr  = mem_addr_q;
    assign pcPlus4  = pc_plus4_q;
    assign instrOut = instr_q;
    assign fault    = fault_q;
    assign busy     = (state_q == REQ);
    assign done     = (state_q == DONE);
    assign dbgState = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus hand-written corner sequences.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RST;
    logic [31:0] pcIn;
    logic        fetchStart;
    logic        flush;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;
    logic [31:0] instrOut;
    logic [31:0] pcPlus4;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  dbgState;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .pcIn       (pcIn),
        .fetchStart (fetchStart),
        .flush      (flush),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memRdata   (memRdata),
        .instrOut   (instrOut),
        .pcPlus4    (pcPlus4),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .dbgState   (dbgState)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          ack_cycle;
        logic [31:0] exp_pc4;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;

        vecs[0] = '{32'h0000_0010, 32'h8C22_0004, 3, 32'h0000_0014, 32'h8C22_0004, 1'b0};
        vecs[1] = '{32'h0000_0006, 32'hFFFF_FFFF, 0, 32'h0000_000A, 32'h8C22_0004, 1'b1};
        vecs[2] = '{32'hFFFF_FFFC, 32'h1234_5678, 1, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[3] = '{32'h0000_0100, 32'hCAFE_F00D, 2, 32'h0000_0104, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{32'h0000_0003, 32'hFFFF_FFFF, 0, 32'h0000_0007, 32'hCAFE_F00D, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0013, 5, 32'h0000_0004, 32'h0000_0013, 1'b0};

        RST = 1'b1; pcIn = '0; fetchStart = 1'b0; flush = 1'b0;
        memAck = 1'b0; memRdata = '0;
        repeat (3) @(negedge CLK);
        check("rst_memReq",   64'(memReq),   64'd0);
        check("rst_memAddr",  64'(memAddr),  64'd0);
        check("rst_instrOut", 64'(instrOut), 64'd0);
        check("rst_pcPlus4",  64'(pcPlus4),  64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_fault",    64'(fault),    64'd0);
        check("rst_state",    64'(dbgState), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            pcIn = vecs[i].pc; fetchStart = 1'b1;
            @(negedge CLK);
            fetchStart = 1'b0;
            check($sformatf("v%0d_memAddr", i), 64'(memAddr), 64'(vecs[i].pc));
            if (!vecs[i].exp_fault) begin
                check($sformatf("v%0d_req_rise", i), 64'(memReq), 64'd1);
                check($sformatf("v%0d_busy", i),     64'(busy),   64'd1);
                for (int j = 1; j < vecs[i].ack_cycle; j++) @(negedge CLK);
                check($sformatf("v%0d_req_hold", i), 64'(memReq), 64'd1);
                memAck = 1'b1; memRdata = vecs[i].rdata;
                @(negedge CLK);
                memAck = 1'b0; memRdata = '0;
            end
            check($sformatf("v%0d_done", i),     64'(done),     64'd1);
            check($sformatf("v%0d_fault", i),    64'(fault),    64'(vecs[i].exp_fault));
            check($sformatf("v%0d_pcPlus4", i),  64'(pcPlus4),  64'(vecs[i].exp_pc4));
            check($sformatf("v%0d_instrOut", i), 64'(instrOut), 64'(vecs[i].exp_instr));
            check($sformatf("v%0d_req_low", i),  64'(memReq),   64'd0);
            check($sformatf("v%0d_busy_low", i), 64'(busy),     64'd0);
            @(negedge CLK);
            check($sformatf("v%0d_done_once", i),  64'(done),     64'd0);
            check($sformatf("v%0d_fault_hold", i), 64'(fault),    64'(vecs[i].exp_fault));
            check($sformatf("v%0d_idle", i),       64'(dbgState), 64'd0);
        end

        // fetchStart together with flush in IDLE is ignored
        pcIn = 32'h0000_0200; fetchStart = 1'b1; flush = 1'b1;
        @(negedge CLK);
        fetchStart = 1'b0; flush = 1'b0;
        check("flush_start_req",   64'(memReq),   64'd0);
        check("flush_start_state", 64'(dbgState), 64'd0);
        check("flush_start_addr",  64'(memAddr),  64'd0);

        // memAck while idle is ignored
        memAck = 1'b1; memRdata = 32'h1111_1111;
        repeat (2) @(negedge CLK);
        memAck = 1'b0; memRdata = '0;
        check("idle_ack_instr", 64'(instrOut), 64'h13);
        check("idle_ack_done",  64'(done),     64'd0);

        // flush and memAck in the same REQ cycle: flush wins
        pcIn = 32'h0000_0020; fetchStart = 1'b1;
        @(negedge CLK);
        fetchStart = 1'b0;
        flush = 1'b1; memAck = 1'b1; memRdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        flush = 1'b0; memAck = 1'b0; memRdata = '0;
        check("race_state", 64'(dbgState), 64'd0);
        check("race_done",  64'(done),     64'd0);
        check("race_req",   64'(memReq),   64'd0);
        check("race_instr", 64'(instrOut), 64'h13);
        @(negedge CLK);
        check("race_no_late_done", 64'(done), 64'd0);

        // fetchStart during REQ and DONE is neither taken nor queued
        pcIn = 32'h0000_0040; fetchStart = 1'b1;
        @(negedge CLK);
        pcIn = 32'h0000_0080;
        @(negedge CLK);
        check("busy_start_addr", 64'(memAddr), 64'h40);
        memAck = 1'b1; memRdata = 32'hA5A5_A5A5;
        @(negedge CLK);
        memAck = 1'b0; memRdata = '0;
        check("busy_start_done",  64'(done),    64'd1);
        check("busy_start_pc4",   64'(pcPlus4), 64'h44);
        check("busy_start_instr", 64'(instrOut), 64'hA5A5_A5A5);
        @(negedge CLK);
        fetchStart = 1'b0;
        check("busy_start_idle", 64'(dbgState), 64'd0);
        check("busy_start_noreq", 64'(memReq),  64'd0);

        // reset in the middle of a request
        pcIn = 32'h0000_0050; fetchStart = 1'b1;
        @(negedge CLK);
        fetchStart = 1'b0;
        check("midrst_req_before", 64'(memReq), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_req",   64'(memReq),   64'd0);
        check("midrst_state", 64'(dbgState), 64'd0);
        check("midrst_instr", 64'(instrOut), 64'd0);
        check("midrst_addr",  64'(memAddr),  64'd0);
        check("midrst_pc4",   64'(pcPlus4),  64'd0);
        check("midrst_done",  64'(done),     64'd0);
        memAck = 1'b1; memRdata = 32'h7777_7777;
        repeat (2) @(negedge CLK);
        memAck = 1'b0; memRdata = '0;
        check("midrst_late_ack_instr", 64'(instrOut), 64'd0);
        check("midrst_late_ack_done",  64'(done),     64'd0);

        // request with no memAck ever
        pcIn = 32'h0000_0060; fetchStart = 1'b1;
        @(negedge CLK);
        fetchStart = 1'b0;
`ifdef IFU_TIMEOUT_EN
        n = 0;
        while (memReq && n < 40) begin
            n++;
            @(negedge CLK);
        end
        check("timeout_req_cycles", 64'(n),        64'd16);
        check("timeout_done",       64'(done),     64'd1);
        check("timeout_fault",      64'(fault),    64'd1);
        check("timeout_instr",      64'(instrOut), 64'd0);
        @(negedge CLK);
        check("timeout_idle", 64'(dbgState), 64'd0);
`else
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (memReq && busy) n++;
            @(negedge CLK);
        end
        check("no_timeout_req_cycles", 64'(n), 64'd100);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("no_timeout_flush_state", 64'(dbgState), 64'd0);
        check("no_timeout_flush_done",  64'(done),     64'd0);
        check("no_timeout_instr",       64'(instrOut), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer side of the program-counter interface in the multicycle CPU.
- Takes the current PC address, issues a single-word read to instruction memory over a req/ack handshake, and latches the returned word into the instruction register.
- Also produces PC+4 for the next-PC mux.
- Sits between the PC register and the memory port; the control FSM starts it once per instruction-fetch phase.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction width.
- TIMEOUT, 16, max cycles to wait for memAck (used only with the optional feature).

Ports:
- CLK  input  1  clock.
- RST  input  1  reset; synchronous, active-high.
- pcIn  input  ADDR_W  current PC value.
- fetchStart  input  1  begin fetch; accepted in IDLE only.
- flush  input  1  abandon the current fetch.
- memReq  output  1  read request to instruction memory.
- memAddr  output  ADDR_W  read address.
- memAck  input  1  memory has returned data this cycle.
- memRdata  input  DATA_W  returned instruction word.
- instrOut  output  DATA_W  instruction register.
- pcPlus4  output  ADDR_W  captured pcIn+4.
- busy  output  1  high in REQ.
- done  output  1  one-cycle completion pulse.
- fault  output  1  fetch failed (misaligned or timeout).

Behaviour:
- Reset and clocking:
  - Single clock CLK. RST is synchronous, active-high, and overrides every other input.
  - All outputs reset to 0; state resets to IDLE.
- States: IDLE, REQ, DONE.
- IDLE:
  - fetchStart=1 and flush=0: memAddr<=pcIn; pcPlus4<=pcIn+4 (mod 2^ADDR_W, so 0xFFFFFFFC gives 0); fault<=0.
  - If pcIn[1:0]!=0: fault<=1, no memory request, go to DONE.
  - Otherwise: memReq<=1, go to REQ.
  - fetchStart with flush=1 is ignored.
- REQ:
  - busy=1, memReq stays high, memAddr stays stable.
  - On memAck=1: instrOut<=memRdata, memReq<=0, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - fetchStart is ignored in REQ and DONE; it is not queued.
- Latency: fetchStart sampled at cycle 0, memReq high from cycle 1; memAck at cycle k gives instrOut valid and done=1 at cycle k+1. Best case is a 2-cycle fetch.
- flush:
  - In REQ: memReq<=0, go to IDLE, no done pulse, instrOut unchanged.
  - flush and memAck in the same cycle: flush wins and the data is discarded.
  - In DONE: no effect.
- memAck while memReq=0 is ignored.
- instrOut holds its last successfully fetched word; faulted or flushed fetches never modify it.
- fault is valid alongside done and holds until the next accepted fetchStart.
- Reset asserted mid-REQ: memReq drops on the next edge; no done pulse.

Optional Feature:
- Macro: IFU_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT+1) clears on entry to REQ and increments each REQ cycle without memAck.
  - When it reaches TIMEOUT, memReq<=0, fault<=1, go to DONE (done pulses); instrOut unchanged.
  - memAck on the same cycle the count reaches TIMEOUT wins: normal completion.
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Package ifu_pkg holds:
  - state enum {IDLE, REQ, DONE};
  - PC_INCR=4;
  - ALIGN_MASK=2'b11;
  - default widths.
- Sub-module ifu_timeout_counter (enable/clear/expired) is natural when IFU_TIMEOUT_EN is defined. Everything else stays in one module.

Test Plan:
- Basic fetch: pcIn=0x00000010, fetchStart 1 cycle, memAck at 3rd REQ cycle with memRdata=0x8C220004 -> memAddr=0x10, instrOut=0x8C220004, pcPlus4=0x14, done pulses 1 cycle, fault=0.
- Misaligned: pcIn=0x00000006, fetchStart -> memReq never asserts, done after 1 cycle with fault=1, instrOut unchanged.
- Wrap: pcIn=0xFFFFFFFC, memAck immediate -> pcPlus4=0x00000000.
- Flush race: in REQ, flush=1 and memAck=1 same cycle with memRdata=0xDEADBEEF -> IDLE, no done, instrOut keeps prior value.
- Reset mid-fetch: RST=1 during REQ -> next edge all outputs 0, state IDLE; later memAck ignored.
- Timeout (IFU_TIMEOUT_EN, TIMEOUT=16): no memAck -> memReq drops after 16 REQ cycles, done=1, fault=1; without the macro memReq stays high for 100+ cycles.
